// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU and branch encodings,
// R-type function codes and the multiplier state type.
package ex_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_LUI   = 4'd8,
        ALU_RTYPE = 4'd15
    } alu_op_t;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_MUL  = 6'h18;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;
    localparam logic [5:0] FUNC_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_BEQ    = 2'b01,
        BR_BNE    = 2'b10,
        BR_ALWAYS = 2'b11
    } branch_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low
// DATA_W bits of the product kept.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MUL_IDLE | waiting for a mul; on start latch operands, clear counter
// MUL_RUN  | one shift-add step per cycle, DATA_W steps in total
// MUL_DONE | product valid; held until a non-stalled edge
module seq_multiplier
    import ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    mul_state_t        state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] a_reg, b_reg, acc;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start && !flush) begin
                    busy      = 1'b1;
                    state_nxt = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                if (count == CNT_W'(DATA_W - 1))
                    state_nxt = MUL_DONE;
            end
            MUL_DONE: begin
                done = 1'b1;
                if (!stall)
                    state_nxt = MUL_IDLE;
            end
            default: state_nxt = MUL_IDLE;
        endcase
        if (flush)
            state_nxt = MUL_IDLE;
        // Reset is synchronous, but the stall request must already be low in the reset cycle.
        if (reset) begin
            busy = 1'b0;
            done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MUL_IDLE;
            count <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                MUL_IDLE: begin
                    if (start && !flush) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                MUL_RUN: begin
                    if (b_reg[0])
                        acc <= acc + a_reg;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch resolution, iterative
// multiply with front-end stall, and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic [DATA_W-1:0]     pc4_in,
    input  logic                  mem_to_reg_in,
    input  logic                  reg_write_in,
    input  logic                  mem_write_in,
    input  logic                  mem_read_in,
    input  logic                  alu_src_in,
    input  logic                  reg_dst_in,
    input  logic [3:0]            alu_op_in,
    input  logic [1:0]            branch_in,
    input  logic [DATA_W-1:0]     imm_ext_in,
    input  logic [REG_ADDR_W-1:0] rs_addr_in,
    input  logic [REG_ADDR_W-1:0] rt_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic [DATA_W-1:0]     rs_data_in,
    input  logic [DATA_W-1:0]     rt_data_in,
    input  logic [5:0]            func_in,
    input  logic                  wb_reg_write_in,
    input  logic [REG_ADDR_W-1:0] wb_addr_in,
    input  logic [DATA_W-1:0]     wb_data_in,
    output logic                  stall_req_out,
    output logic                  mem_to_reg_out,
    output logic                  reg_write_out,
    output logic                  mem_write_out,
    output logic                  mem_read_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] wr_addr_out,
    output logic                  branch_taken_out,
    output logic [DATA_W-1:0]     branch_target_out
);

    logic [DATA_W-1:0]     fwd_rs, fwd_rt, op_a, op_b;
    logic [DATA_W-1:0]     alu_res, br_target, mul_product;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [4:0]            shamt;
    logic                  is_mul, mul_busy, mul_done, br_taken;
    logic                  exmem_fwd_ok, wb_fwd_ok;

    // Loads in EX/MEM have no data yet; the hazard unit stalls those.
    assign exmem_fwd_ok = reg_write_out && !mem_read_out && (wr_addr_out != '0);
    assign wb_fwd_ok    = wb_reg_write_in && (wb_addr_in != '0);

    always_comb begin
        if (exmem_fwd_ok && (wr_addr_out == rs_addr_in))
            fwd_rs = alu_result_out;
        else if (wb_fwd_ok && (wb_addr_in == rs_addr_in))
            fwd_rs = wb_data_in;
        else
            fwd_rs = rs_data_in;

        if (exmem_fwd_ok && (wr_addr_out == rt_addr_in))
            fwd_rt = alu_result_out;
        else if (wb_fwd_ok && (wb_addr_in == rt_addr_in))
            fwd_rt = wb_data_in;
        else
            fwd_rt = rt_data_in;
    end

    assign op_a    = fwd_rs;
    assign op_b    = alu_src_in ? imm_ext_in : fwd_rt;
    assign wr_addr = reg_dst_in ? rd_addr_in : rt_addr_in;
    assign shamt   = imm_ext_in[10:6];
    assign is_mul  = (alu_op_in == ALU_RTYPE) && (func_in == FUNC_MUL);

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush_in),
        .stall   (stall_in),
        .start   (is_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign stall_req_out = mul_busy;

    always_comb begin
        alu_res = '0;
        case (alu_op_in)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = DATA_W'(op_a < op_b);
            ALU_LUI:  alu_res = op_b << 16;
            ALU_RTYPE: begin
                case (func_in)
                    FUNC_ADD:  alu_res = op_a + op_b;
                    FUNC_SUB:  alu_res = op_a - op_b;
                    FUNC_AND:  alu_res = op_a & op_b;
                    FUNC_OR:   alu_res = op_a | op_b;
                    FUNC_XOR:  alu_res = op_a ^ op_b;
                    FUNC_NOR:  alu_res = ~(op_a | op_b);
                    FUNC_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
                    FUNC_SLTU: alu_res = DATA_W'(op_a < op_b);
                    FUNC_SLL:  alu_res = fwd_rt << shamt;
                    FUNC_SRL:  alu_res = fwd_rt >> shamt;
                    FUNC_SRA:  alu_res = $signed(fwd_rt) >>> shamt;
                    FUNC_MUL:  alu_res = mul_done ? mul_product : '0;
                    default:   alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    assign br_target = pc4_in + (imm_ext_in << 2);

    always_comb begin
        br_taken = 1'b0;
        case (branch_in)
            BR_BEQ:    br_taken = (fwd_rs == fwd_rt);
            BR_BNE:    br_taken = (fwd_rs != fwd_rt);
            BR_ALWAYS: br_taken = 1'b1;
            default:   br_taken = 1'b0;
        endcase
    end

    // While the multiplier is busy the held mul must not reach MEM, so bubbles go down.
    always_ff @(posedge clk) begin
        if (reset || flush_in || (!stall_in && mul_busy)) begin
            mem_to_reg_out    <= 1'b0;
            reg_write_out     <= 1'b0;
            mem_write_out     <= 1'b0;
            mem_read_out      <= 1'b0;
            alu_result_out    <= '0;
            store_data_out    <= '0;
            wr_addr_out       <= '0;
            branch_taken_out  <= 1'b0;
            branch_target_out <= '0;
        end else if (!stall_in) begin
            mem_to_reg_out    <= mem_to_reg_in;
            reg_write_out     <= reg_write_in;
            mem_write_out     <= mem_write_in;
            mem_read_out      <= mem_read_in;
            alu_result_out    <= alu_res;
            store_data_out    <= fwd_rt;
            wr_addr_out       <= wr_addr;
            branch_taken_out  <= br_taken;
            branch_target_out <= br_target;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and compared when the stage captures it.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in;
    logic [31:0] pc4_in;
    logic        mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in, alu_src_in, reg_dst_in;
    logic [3:0]  alu_op_in;
    logic [1:0]  branch_in;
    logic [31:0] imm_ext_in;
    logic [4:0]  rs_addr_in, rt_addr_in, rd_addr_in;
    logic [31:0] rs_data_in, rt_data_in;
    logic [5:0]  func_in;
    logic        wb_reg_write_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        stall_req_out, mem_to_reg_out, reg_write_out, mem_write_out, mem_read_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  wr_addr_out;
    logic        branch_taken_out;
    logic [31:0] branch_target_out;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  wr;
        logic        rw;
        logic [31:0] store;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .pc4_in(pc4_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
        .mem_read_in(mem_read_in), .alu_src_in(alu_src_in), .reg_dst_in(reg_dst_in),
        .alu_op_in(alu_op_in), .branch_in(branch_in), .imm_ext_in(imm_ext_in),
        .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in),
        .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .func_in(func_in),
        .wb_reg_write_in(wb_reg_write_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .stall_req_out(stall_req_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .mem_write_out(mem_write_out), .mem_read_out(mem_read_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .wr_addr_out(wr_addr_out), .branch_taken_out(branch_taken_out),
        .branch_target_out(branch_target_out)
    );

    always #5 clk = ~clk;

    task automatic set_nop();
        stall_in = 0; flush_in = 0; pc4_in = 0;
        mem_to_reg_in = 0; reg_write_in = 0; mem_write_in = 0; mem_read_in = 0;
        alu_src_in = 0; reg_dst_in = 0; alu_op_in = 4'd0; branch_in = 2'd0; imm_ext_in = 0;
        rs_addr_in = 0; rt_addr_in = 0; rd_addr_in = 0; rs_data_in = 0; rt_data_in = 0;
        func_in = 0; wb_reg_write_in = 0; wb_addr_in = 0; wb_data_in = 0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [5:0] fn,
                            input logic [4:0] rs_a, input logic [31:0] rs_d,
                            input logic [4:0] rt_a, input logic [31:0] rt_d,
                            input logic [4:0] rd_a, input logic [31:0] imm,
                            input logic src, input logic dst, input logic rw);
        alu_op_in = op; func_in = fn; rs_addr_in = rs_a; rs_data_in = rs_d;
        rt_addr_in = rt_a; rt_data_in = rt_d; rd_addr_in = rd_a; imm_ext_in = imm;
        alu_src_in = src; reg_dst_in = dst; reg_write_in = rw;
        mem_to_reg_in = 0; mem_write_in = 0; mem_read_in = 0; branch_in = 0; pc4_in = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            {stall_in, flush_in, mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in} = 6'($urandom);
            {alu_src_in, reg_dst_in, alu_op_in, branch_in} = 8'($urandom);
            alu_op_in = 4'd15; func_in = 6'h18;
            pc4_in = $urandom; imm_ext_in = $urandom; rs_data_in = $urandom; rt_data_in = $urandom;
            {rs_addr_in, rt_addr_in, rd_addr_in, wb_addr_in} = 20'($urandom);
            wb_reg_write_in = 1'($urandom); wb_data_in = $urandom;
            @(posedge clk); #1;
        end
        total++; if (stall_req_out !== 1'b0) begin bad++; $display("FAIL reset stall_req: got %b want 0", stall_req_out); end
        total++; if ({mem_to_reg_out, reg_write_out, mem_write_out, mem_read_out} !== 4'b0) begin
            bad++; $display("FAIL reset ctrl: got %b want 0000", {mem_to_reg_out, reg_write_out, mem_write_out, mem_read_out}); end
        total++; if (alu_result_out !== 32'h0) begin bad++; $display("FAIL reset result: got %h want 0", alu_result_out); end
        total++; if (store_data_out !== 32'h0) begin bad++; $display("FAIL reset store: got %h want 0", store_data_out); end
        total++; if (wr_addr_out !== 5'h0) begin bad++; $display("FAIL reset wr_addr: got %h want 0", wr_addr_out); end
        total++; if ({branch_taken_out, branch_target_out} !== 33'h0) begin
            bad++; $display("FAIL reset branch: got %b/%h want 0/0", branch_taken_out, branch_target_out); end
        reset = 0;
        set_nop();
    endtask

    task automatic test_rtype_add();
        drive_op(4'd15, 6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 0, 1, 1);
        sb.push_back('{result: 32'd12, wr: 5'd3, rw: 1'b1, store: 32'd7, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL add result: got %h want %h", alu_result_out, e.result); end
        total++; if (wr_addr_out !== e.wr) begin bad++; $display("FAIL add wr_addr: got %0d want %0d", wr_addr_out, e.wr); end
        total++; if (reg_write_out !== e.rw) begin bad++; $display("FAIL add reg_write: got %b want %b", reg_write_out, e.rw); end
        total++; if (store_data_out !== e.store) begin bad++; $display("FAIL add store: got %h want %h", store_data_out, e.store); end
    endtask

    task automatic test_back_to_back();
        // addi r4 = r3 + 4 right behind the r3 = 12 add; WB also writing r3 = 99
        drive_op(4'd0, 6'h0, 5'd3, 32'd0, 5'd4, 32'd0, 5'd0, 32'd4, 1, 0, 1);
        wb_reg_write_in = 1; wb_addr_in = 5'd3; wb_data_in = 32'd99;
        sb.push_back('{result: 32'd16, wr: 5'd4, rw: 1'b1, store: 32'd0, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL fwd exmem result: got %0d want %0d", alu_result_out, e.result); end
        total++; if (wr_addr_out !== e.wr) begin bad++; $display("FAIL fwd exmem wr_addr: got %0d want %0d", wr_addr_out, e.wr); end
        // rs from EX/MEM (r4=16), rt from WB (r3=99)
        drive_op(4'd0, 6'h0, 5'd4, 32'd0, 5'd3, 32'd0, 5'd6, 32'd0, 0, 1, 1);
        sb.push_back('{result: 32'd115, wr: 5'd6, rw: 1'b1, store: 32'd99, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL fwd wb result: got %0d want %0d", alu_result_out, e.result); end
        total++; if (store_data_out !== e.store) begin bad++; $display("FAIL fwd wb store: got %0d want %0d", store_data_out, e.store); end
        wb_reg_write_in = 0;
        // write r0, then read r0 with WB also claiming r0
        drive_op(4'd0, 6'h0, 5'd1, 32'd1, 5'd0, 32'd0, 5'd0, 32'd100, 1, 0, 1);
        sb.push_back('{result: 32'd101, wr: 5'd0, rw: 1'b1, store: 32'd0, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL r0 write result: got %0d want %0d", alu_result_out, e.result); end
        drive_op(4'd0, 6'h0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'd1, 1, 1, 1);
        wb_reg_write_in = 1; wb_addr_in = 5'd0; wb_data_in = 32'd77;
        sb.push_back('{result: 32'd1, wr: 5'd9, rw: 1'b1, store: 32'd0, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL r0 no-fwd result: got %0d want %0d", alu_result_out, e.result); end
        total++; if (store_data_out !== e.store) begin bad++; $display("FAIL r0 no-fwd store: got %0d want %0d", store_data_out, e.store); end
        wb_reg_write_in = 0; wb_addr_in = 0; wb_data_in = 0;
        // load into r8, then read r8: a load in EX/MEM must not forward
        drive_op(4'd0, 6'h0, 5'd1, 32'h1000, 5'd8, 32'd0, 5'd0, 32'd8, 1, 0, 1);
        mem_read_in = 1; mem_to_reg_in = 1;
        sb.push_back('{result: 32'h1008, wr: 5'd8, rw: 1'b1, store: 32'd0, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if ({alu_result_out, mem_read_out, mem_to_reg_out} !== {e.result, 2'b11}) begin
            bad++; $display("FAIL load capture: got %h/%b%b want %h/11", alu_result_out, mem_read_out, mem_to_reg_out, e.result); end
        drive_op(4'd0, 6'h0, 5'd8, 32'h55, 5'd0, 32'd0, 5'd0, 32'd0, 1, 0, 0);
        sb.push_back('{result: 32'h55, wr: 5'd0, rw: 1'b0, store: 32'd0, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL load no-fwd result: got %h want %h", alu_result_out, e.result); end
        set_nop();
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } alu_row_t;

    task automatic test_alu_ops();
        alu_row_t rows[16];
        rows[0]  = '{4'd1,  6'h00, 32'd5,         32'd7,         32'hFFFFFFFE};
        rows[1]  = '{4'd2,  6'h00, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000};
        rows[2]  = '{4'd3,  6'h00, 32'hF0F0F0F0,  32'hFF00FF00,  32'hFFF0FFF0};
        rows[3]  = '{4'd4,  6'h00, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0};
        rows[4]  = '{4'd5,  6'h00, 32'hF0F0F0F0,  32'hFF00FF00,  32'h000F000F};
        rows[5]  = '{4'd6,  6'h00, 32'hFFFFFFFB,  32'd3,         32'd1};
        rows[6]  = '{4'd7,  6'h00, 32'hFFFFFFFB,  32'd3,         32'd0};
        rows[7]  = '{4'd8,  6'h00, 32'd0,         32'h1234,      32'h12340000};
        rows[8]  = '{4'd15, 6'h00, 32'd0,         32'h80000011,  32'h00000044};
        rows[9]  = '{4'd15, 6'h02, 32'd0,         32'h80000011,  32'h20000004};
        rows[10] = '{4'd15, 6'h03, 32'd0,         32'h80000011,  32'hE0000004};
        rows[11] = '{4'd15, 6'h2A, 32'd3,         32'hFFFFFFFB,  32'd0};
        rows[12] = '{4'd15, 6'h2B, 32'd3,         32'hFFFFFFFB,  32'd1};
        rows[13] = '{4'd9,  6'h00, 32'd1,         32'd2,         32'd0};
        rows[14] = '{4'd15, 6'h3F, 32'd1,         32'd2,         32'd0};
        rows[15] = '{4'd15, 6'h20, 32'hFFFFFFFF,  32'd2,         32'd1};
        foreach (rows[i]) begin
            // shift amount field imm[10:6] = 2
            drive_op(rows[i].op, rows[i].fn, 5'd10, rows[i].a, 5'd11, rows[i].b, 5'd12, 32'h80, 0, 1, 0);
            sb.push_back('{result: rows[i].res, wr: 5'd12, rw: 1'b0, store: rows[i].b, taken: 1'b0, target: 32'h200});
            #1;
            total++; if (stall_req_out !== 1'b0) begin bad++; $display("FAIL alu row %0d stall_req: got %b want 0", i, stall_req_out); end
            @(posedge clk); #1;
            e = sb.pop_front();
            total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL alu row %0d result: got %h want %h", i, alu_result_out, e.result); end
        end
        set_nop();
    endtask

    typedef struct packed {
        logic [1:0]  br;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
    } br_row_t;

    task automatic test_branch();
        br_row_t rows[6];
        rows[0] = '{2'b01, 32'd9, 32'd9, 1'b1};
        rows[1] = '{2'b10, 32'd9, 32'd9, 1'b0};
        rows[2] = '{2'b01, 32'd9, 32'd8, 1'b0};
        rows[3] = '{2'b10, 32'd9, 32'd8, 1'b1};
        rows[4] = '{2'b11, 32'd1, 32'd2, 1'b1};
        rows[5] = '{2'b00, 32'd9, 32'd9, 1'b0};
        foreach (rows[i]) begin
            drive_op(4'd1, 6'h0, 5'd12, rows[i].a, 5'd13, rows[i].b, 5'd0, 32'hFFFFFFFE, 0, 0, 0);
            branch_in = rows[i].br; pc4_in = 32'h100;
            sb.push_back('{result: rows[i].a - rows[i].b, wr: 5'd13, rw: 1'b0, store: rows[i].b, taken: rows[i].taken, target: 32'h000000F8});
            @(posedge clk); #1;
            e = sb.pop_front();
            total++; if (branch_taken_out !== e.taken) begin bad++; $display("FAIL branch row %0d taken: got %b want %b", i, branch_taken_out, e.taken); end
            total++; if (branch_target_out !== e.target) begin bad++; $display("FAIL branch row %0d target: got %h want %h", i, branch_target_out, e.target); end
        end
        set_nop();
    endtask

    task automatic test_mul();
        int   stall_cycles = 0;
        int   edges = 0;
        logic bubble_ok = 1'b1;
        logic [31:0] a = 32'hFFFFFFFF;
        logic [31:0] b = 32'd3;
        logic [63:0] full = 64'(a) * 64'(b);
        drive_op(4'd15, 6'h18, 5'd14, a, 5'd15, b, 5'd5, 32'h0, 0, 1, 1);
        sb.push_back('{result: full[31:0], wr: 5'd5, rw: 1'b1, store: b, taken: 1'b0, target: 32'h0});
        #1;
        total++; if (stall_req_out !== 1'b1) begin bad++; $display("FAIL mul first-cycle stall_req: got %b want 1", stall_req_out); end
        if (stall_req_out) stall_cycles = 1;
        while (edges < 100) begin
            @(posedge clk); #1; edges++;
            if (!stall_req_out) break;
            stall_cycles++;
            if (reg_write_out !== 1'b0) bubble_ok = 1'b0;
        end
        total++; if (edges >= 100) begin bad++; $display("FAIL mul timeout: stall_req still %b after %0d edges", stall_req_out, edges); end
        total++; if (stall_cycles != 33) begin bad++; $display("FAIL mul stall length: got %0d want 33", stall_cycles); end
        total++; if (!bubble_ok) begin bad++; $display("FAIL mul bubbles: reg_write_out seen 1 want 0"); end
        @(posedge clk); #1;
        set_nop();
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL mul result: got %h want %h", alu_result_out, e.result); end
        total++; if ({reg_write_out, wr_addr_out} !== {e.rw, e.wr}) begin
            bad++; $display("FAIL mul dest: got %b/%0d want %b/%0d", reg_write_out, wr_addr_out, e.rw, e.wr); end
    endtask

    task automatic test_mul_flush();
        drive_op(4'd15, 6'h18, 5'd14, 32'd7, 5'd15, 32'd6, 5'd5, 32'h0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        total++; if (stall_req_out !== 1'b1) begin bad++; $display("FAIL flush pre stall_req: got %b want 1", stall_req_out); end
        flush_in = 1;
        @(posedge clk); #1;
        flush_in = 0;
        drive_op(4'd0, 6'h0, 5'd1, 32'd20, 5'd2, 32'd22, 5'd9, 32'h0, 0, 1, 1);
        sb.push_back('{result: 32'd42, wr: 5'd9, rw: 1'b1, store: 32'd22, taken: 1'b0, target: 32'h0});
        #1;
        total++; if (stall_req_out !== 1'b0) begin bad++; $display("FAIL flush stall_req: got %b want 0", stall_req_out); end
        total++; if ({reg_write_out, alu_result_out, wr_addr_out} !== 38'h0) begin
            bad++; $display("FAIL flush bubble: got %b/%h/%0d want 0/0/0", reg_write_out, alu_result_out, wr_addr_out); end
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if ({alu_result_out, wr_addr_out, reg_write_out} !== {e.result, e.wr, e.rw}) begin
            bad++; $display("FAIL flush next add: got %0d/%0d/%b want %0d/%0d/%b", alu_result_out, wr_addr_out, reg_write_out, e.result, e.wr, e.rw); end
        set_nop();
    endtask

    task automatic test_stall();
        drive_op(4'd0, 6'h0, 5'd1, 32'd100, 5'd2, 32'd1, 5'd7, 32'h0, 0, 1, 1);
        sb.push_back('{result: 32'd101, wr: 5'd7, rw: 1'b1, store: 32'd1, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if (alu_result_out !== e.result) begin bad++; $display("FAIL stall setup result: got %0d want %0d", alu_result_out, e.result); end
        drive_op(4'd0, 6'h0, 5'd1, 32'd50, 5'd2, 32'd50, 5'd8, 32'h0, 0, 1, 1);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if ({alu_result_out, wr_addr_out, store_data_out} !== {32'd101, 5'd7, 32'd1}) begin
                bad++; $display("FAIL stall hold %0d: got %0d/%0d/%0d want 101/7/1", i, alu_result_out, wr_addr_out, store_data_out); end
        end
        stall_in = 0;
        sb.push_back('{result: 32'd100, wr: 5'd8, rw: 1'b1, store: 32'd50, taken: 1'b0, target: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        total++; if ({alu_result_out, wr_addr_out} !== {e.result, e.wr}) begin
            bad++; $display("FAIL stall release: got %0d/%0d want %0d/%0d", alu_result_out, wr_addr_out, e.result, e.wr); end
        set_nop();
    endtask

    initial begin
        set_nop();
        reset = 1;
        @(posedge clk); #1;
        test_reset();
        test_rtype_add();
        test_back_to_back();
        test_alu_ops();
        test_branch();
        test_mul();
        test_mul_flush();
        test_stall();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline-register outputs and resolves operand forwarding from EX/MEM and WB. It computes the ALU result and branch decision, and runs an iterative 32-cycle multiplier that stalls the front end. It contains the EX/MEM pipeline register, with stall and flush control, that feeds the memory stage.

Parameters:
DATA_W, 32, datapath width; the multiplier takes DATA_W iteration cycles.
REG_ADDR_W, 5, register-file address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_in  in  1  hold EX/MEM contents (downstream stall)
flush_in  in  1  load a bubble into EX/MEM and abort any multiply
pc4_in  in  32  PC+4 from ID/EX
mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in, alu_src_in, reg_dst_in  in  1 each  control bits from ID/EX
alu_op_in  in  4  ALU operation (alu_op_t)
branch_in  in  2  branch type (branch_t)
imm_ext_in  in  32  sign-extended immediate
rs_addr_in, rt_addr_in, rd_addr_in  in  5 each  register addresses
rs_data_in, rt_data_in  in  32 each  register-file read data
func_in  in  6  R-type function field
wb_reg_write_in  in  1  WB-stage write enable
wb_addr_in  in  5  WB-stage destination
wb_data_in  in  32  WB-stage write data
stall_req_out  out  1  multiplier busy; ID/EX and earlier stages must hold
mem_to_reg_out, reg_write_out, mem_write_out, mem_read_out  out  1 each  registered control bits to MEM
alu_result_out  out  32  registered result
store_data_out  out  32  registered forwarded rt value
wr_addr_out  out  5  registered destination register
branch_taken_out  out  1  registered branch decision
branch_target_out  out  32  registered branch target

Behaviour:
- Reset: every registered output is 0. The FSM returns to IDLE. stall_req_out is 0.
- Register update priority: reset > flush_in > stall_in > normal capture.
- flush_in: all EX/MEM fields are cleared to 0, which is a bubble.
- stall_in: all EX/MEM fields hold their values.
- Forwarding (rs and rt independently):
  - Source 1, if matching: EX/MEM, when reg_write_out=1, mem_read_out=0, wr_addr_out!=0 and wr_addr_out equals the source address. Load-use is the hazard unit's job.
  - Source 2, if matching: WB, when wb_reg_write_in=1, wb_addr_in!=0 and the addresses match.
  - Otherwise: the register-file data input.
  - Register 0 is never forwarded.
- Operands: A = forwarded rs. B = imm_ext_in when alu_src_in=1, otherwise forwarded rt. store_data_out is always the forwarded rt value.
- Destination: wr_addr = rd_addr_in when reg_dst_in=1, otherwise rt_addr_in.
- ALU encodings (alu_op_in):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 LUI (B<<16).
  - 15 RTYPE: decode func_in as 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra, 0x18 mul.
  - Shift amount is imm_ext_in[10:6]; shifts act on the rt operand.
  - Unknown alu_op or func produces a result of 0.
- Arithmetic: add/sub wrap modulo 2^32 with no overflow trap. mul returns the low 32 bits of the product.
- Branch encodings (branch_in): 00 none, 01 beq (A==fwd rt), 10 bne, 11 always taken.
  - Target = pc4_in + (imm_ext_in<<2), modulo 2^32.
  - Taken and target are captured in EX/MEM with a 1-cycle latency.
- Multiplier FSM, states IDLE, MUL, DONE:
  - IDLE, with a mul instruction present and no flush: stall_req_out=1 combinationally. Latch A and B and clear the counter. Load a bubble into EX/MEM unless stall_in is high. Go to MUL.
  - MUL: one shift-add step per cycle, stall_req_out=1. After DATA_W steps, go to DONE. The counter keeps running while stall_in is high.
  - DONE: stall_req_out=0. ID/EX still holds the mul instruction. EX/MEM captures it with the product as its result. Return to IDLE on a non-stalled edge; otherwise hold DONE.
  - Timing: stall_req_out is high for exactly DATA_W+1 cycles. The result appears in EX/MEM DATA_W+2 edges after the mul arrives.
  - flush_in in any state: go to IDLE, stall_req_out=0 from the next cycle, product discarded.
- All non-mul operations have 1-cycle latency and never assert stall_req_out.

Decomposition:
- Package ex_pkg holds alu_op_t, the func constants, branch_t, and the DATA_W/REG_ADDR_W defaults.
- One sub-module, seq_multiplier, contains the FSM, counter and shift-add datapath. Its interface is start, a, b, busy, done and product.
- The ALU and forwarding muxes stay inline.

Test Plan:
- Reset asserted for 2 cycles with random inputs -> every output 0, stall_req_out=0.
- RTYPE func 0x20, rs_data=5, rt_data=7, reg_dst=1, rd=3, reg_write=1 -> next edge gives alu_result_out=12, wr_addr_out=3, reg_write_out=1.
- Back-to-back ADDI r4=r3+4 with stale rs_data=0 -> result 16 (EX/MEM forward).
  - WB writing r3=99 in the same cycle -> still 16 (EX/MEM has priority).
  - Destination r0 -> never forwarded.
- beq with rs=rt=9, pc4=0x100, imm=0xFFFFFFFE -> branch_taken_out=1, target 0x000000F8.
  - Same operands with bne -> taken 0.
- mul 0xFFFFFFFF*3 -> stall_req_out high for 33 cycles with reg_write_out=0 bubbles, then alu_result_out=0xFFFFFFFD.
- flush_in at multiply cycle 10 -> stall_req_out=0 next cycle and EX/MEM zeroed. A following ADD completes in 1 cycle.
  - stall_in held 3 cycles -> outputs unchanged.
